// File: rtl/shift_arbiter.sv
// Round-robin shared 32-bit iterative shifter for two requesters; result after 2 + ceil(amt/STEP) cycles from grant.
// Grants only in IDLE; result held in DONE until i_out_ready, so the consumer stalls the unit and both requesters.
module shift_arbiter #(
  parameter int STEP = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req0,
  input  logic [31:0] i_in0,
  input  logic [4:0]  i_amt0,
  input  logic        i_dir0,
  output logic        o_gnt0,
  input  logic        i_req1,
  input  logic [31:0] i_in1,
  input  logic [4:0]  i_amt1,
  input  logic        i_dir1,
  output logic        o_gnt1,
  output logic [31:0] o_out,
  output logic        o_out_id,
  output logic        o_out_valid,
  input  logic        i_out_ready
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [4:0] STEP_AMT = 5'(STEP);

  logic [1:0]  r_state;
  logic [31:0] r_acc;
  logic [4:0]  r_rem;
  logic        r_dir;
  logic        r_id;
  logic        r_last;

  logic        w_idle;
  logic        w_gnt0;
  logic        w_gnt1;
  logic [4:0]  w_k;

  // r_last names the most recently served requester; on contention the other one wins.
  assign w_idle = (r_state == S_IDLE) && !i_rst;
  assign w_gnt0 = w_idle && i_req0 && (!i_req1 || r_last);
  assign w_gnt1 = w_idle && i_req1 && (!i_req0 || !r_last);
  assign w_k    = (r_rem < STEP_AMT) ? r_rem : STEP_AMT;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_acc   <= 32'd0;
      r_rem   <= 5'd0;
      r_dir   <= 1'b0;
      r_id    <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt0) begin
            r_acc   <= i_in0;
            r_rem   <= i_amt0;
            r_dir   <= i_dir0;
            r_id    <= 1'b0;
            r_last  <= 1'b0;
            r_state <= S_SHIFT;
          end else if (w_gnt1) begin
            r_acc   <= i_in1;
            r_rem   <= i_amt1;
            r_dir   <= i_dir1;
            r_id    <= 1'b1;
            r_last  <= 1'b1;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          // The Rem=0 cycle is the exit cycle, so even a zero shift spends one cycle here.
          if (r_rem == 5'd0) begin
            r_state <= S_DONE;
          end else begin
            r_acc <= r_dir ? (r_acc >> w_k) : (r_acc << w_k);
            r_rem <= r_rem - w_k;
          end
        end
        S_DONE: begin
          if (i_out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_gnt0      = w_gnt0;
  assign o_gnt1      = w_gnt1;
  assign o_out       = r_acc;
  assign o_out_id    = r_id;
  assign o_out_valid = (r_state == S_DONE);

endmodule

// File: tb/tb_shift_arbiter.sv
// Randomized and directed bench for shift_arbiter against a transaction-level reference model.
module tb_shift_arbiter;
  localparam int STEP = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, dir0, dir1, out_ready;
  logic [31:0] in0, in1;
  logic [4:0]  amt0, amt1;
  logic        gnt0, gnt1, out_id, out_valid;
  logic [31:0] out;

  int checks = 0;
  int errors = 0;
  bit m_last;

  always #5 clk = ~clk;

  shift_arbiter #(.STEP(STEP)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0(req0), .i_in0(in0), .i_amt0(amt0), .i_dir0(dir0), .o_gnt0(gnt0),
    .i_req1(req1), .i_in1(in1), .i_amt1(amt1), .i_dir1(dir1), .o_gnt1(gnt1),
    .o_out(out), .o_out_id(out_id), .o_out_valid(out_valid), .i_out_ready(out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] v, input int a, input bit d);
    return d ? (v >> a) : (v << a);
  endfunction

  function automatic int ref_lat(input int a);
    return (a == 0) ? 2 : 2 + (a + STEP - 1) / STEP;
  endfunction

  // One transaction: present requests in an IDLE cycle, follow the winner to DONE, stall, then hand shake.
  task automatic txn(input bit r0, input bit r1,
                     input logic [31:0] a0, input int m0, input bit d0,
                     input logic [31:0] a1, input int m1, input bit d1,
                     input int stall);
    bit          id;
    logic [31:0] eo;
    int          lat;
    int          n;
    @(negedge clk);
    req0 = r0; in0 = a0; amt0 = m0[4:0]; dir0 = d0;
    req1 = r1; in1 = a1; amt1 = m1[4:0]; dir1 = d1;
    out_ready = 1'b0;
    #1;
    chk("idle_valid", {31'd0, out_valid}, 32'd0);
    id = (r0 && r1) ? ~m_last : r1;
    chk("gnt0", {31'd0, gnt0}, {31'd0, id == 1'b0});
    chk("gnt1", {31'd0, gnt1}, {31'd0, id == 1'b1});
    m_last = id;
    eo  = id ? ref_shift(a1, m1, d1) : ref_shift(a0, m0, d0);
    lat = ref_lat(id ? m1 : m0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (id) req1 = 1'b0; else req0 = 1'b0;
      #1;
      if (!out_valid) chk("gnt_busy", {30'd0, gnt0, gnt1}, 32'd0);
    end while (!out_valid && n < 60);
    chk("latency", n, lat);
    chk("out", out, eo);
    chk("out_id", {31'd0, out_id}, {31'd0, id});
    for (int w = 0; w < stall; w++) begin
      @(negedge clk);
      #1;
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_out", out, eo);
      chk("stall_id", {31'd0, out_id}, {31'd0, id});
      chk("stall_gnt", {30'd0, gnt0, gnt1}, 32'd0);
    end
    out_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b0;
    req0 = 1'b1; req1 = 1'b1; in0 = '0; in1 = '0; amt0 = '0; amt1 = '0; dir0 = 1'b0; dir1 = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("rst_gnt", {30'd0, gnt0, gnt1}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    #1;
    chk("rst_out", out, 32'd0);
    chk("rst_id", {31'd0, out_id}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    m_last = 1'b1;

    txn(1, 0, 32'h5, 1, 0, 32'h0, 0, 0, 0);
    txn(0, 1, 32'h0, 0, 0, 32'hC, 3, 1, 0);
    txn(0, 1, 32'h0, 0, 0, 32'h3, 0, 0, 0);
    txn(1, 0, 32'h1, 20, 0, 32'h0, 0, 0, 0);
    txn(1, 0, 32'hFFFF_FFFF, 31, 0, 32'h0, 0, 0, 0);
    txn(1, 0, 32'h8000_1234, 31, 1, 32'h0, 0, 0, 5);
    for (int i = 0; i < 4; i++)
      txn(1, 1, 32'hA5A5_0000 + i, 4 * i + 1, 0, 32'h0F0F_0000 + i, 8 * i + 3, 1, 0);

    for (int i = 0; i < 40; i++) begin
      int pat;
      pat = $urandom_range(1, 3);
      txn(pat[0], pat[1], $urandom, $urandom_range(0, 31), 1'($urandom_range(0, 1)),
          $urandom, $urandom_range(0, 31), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    // Reset in the middle of a long shift, then contention must go to requester 0.
    @(negedge clk);
    out_ready = 1'b0;
    req0 = 1'b1; in0 = 32'h1; amt0 = 5'd31; dir0 = 1'b0; req1 = 1'b0;
    #1;
    chk("pre_rst_gnt0", {31'd0, gnt0}, 32'd1);
    @(negedge clk);
    req0 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_out", out, 32'd0);
    chk("midrst_id", {31'd0, out_id}, 32'd0);
    m_last = 1'b1;
    txn(1, 1, 32'h7, 2, 0, 32'h70, 4, 1, 0);
    txn(1, 1, 32'h7, 2, 0, 32'h70, 4, 1, 1);

    @(negedge clk);
    out_ready = 1'b0; req0 = 1'b0; req1 = 1'b0;
    #1;
    chk("final_valid", {31'd0, out_valid}, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one iterative 32-bit shift unit between two requesters, e.g. ALU shift ops and the branch-offset/immediate path.
- Each requester presents an operand, shift amount and direction. The block arbitrates round-robin and performs the shift in STEP-bit increments over several cycles.
- It returns the result with a valid/ready handshake tagged with the requester ID.
- It sits beside the ALU and replaces per-requester combinational left-shifters.

Parameters:
- STEP, 8, maximum bits shifted per cycle; legal range 1..31.

Ports:
- Clk  in  1  clock; all state updates on rising edge
- Rst  in  1  synchronous reset, active-high
- Req0  in  1  requester 0 request; held high with operands stable until Gnt0 is seen
- In0  in  32  requester 0 operand
- Amt0  in  5  requester 0 shift amount, 0..31
- Dir0  in  1  requester 0 direction: 0 = logical left, 1 = logical right
- Gnt0  out  1  requester 0 accepted this cycle
- Req1  in  1  requester 1 request
- In1  in  32  requester 1 operand
- Amt1  in  5  requester 1 shift amount
- Dir1  in  1  requester 1 direction
- Gnt1  out  1  requester 1 accepted this cycle
- Out  out  32  shifted result; meaningful only while OutValid=1
- OutId  out  1  requester that owns Out
- OutValid  out  1  result available
- OutReady  in  1  consumer accepts result

Behaviour:
- Reset:
  - Rst is synchronous, active-high, and wins over every other input, including in mid-operation.
  - On reset: state=IDLE, Out=0, OutId=0, OutValid=0, Gnt0=Gnt1=0, Last=1 (requester 0 has priority first).
  - Any in-flight shift is discarded and no result is produced.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - Gnt0/Gnt1 are combinational from Req0/Req1 and Last, asserted only in IDLE with Rst=0. At most one Gnt is high in any cycle.
  - Only Req0: grant 0. Only Req1: grant 1. Both: grant the requester != Last.
  - At the granting edge: latch operand into the accumulator, amount into Rem, direction into Dir, ID into OutId, and set Last=ID. Next state is SHIFT.
  - No request: stay in IDLE.
- SHIFT:
  - If Rem=0: go to DONE.
  - Else: k=min(Rem,STEP); accumulator shifts left or right by k with zero fill; Rem-=k; stay in SHIFT.
  - Cycles spent in SHIFT = max(1, ceil(Amt/STEP)+1 when Amt>0 ... simplified: Amt/STEP rounded up, plus 1 for the Rem=0 exit cycle).
  - Exact count: Amt=0 gives 1 cycle; Amt>0 gives ceil(Amt/STEP)+1 cycles.
- DONE:
  - OutValid=1. Out and OutId are held stable until OutReady=1 is sampled.
  - On OutValid & OutReady at the edge: OutValid drops, next state is IDLE.
  - No new grant can occur in the same cycle as the handshake. The earliest next Gnt is in the following IDLE cycle.
- Requests during SHIFT/DONE:
  - Ignored; Gnt stays 0.
  - The requester keeps Req high and is served later. Round-robin guarantees it within one extra transaction.
- Out is the accumulator register. During SHIFT it shows intermediate values, which are don't-care while OutValid=0.
- Amounts are 5 bits, so Amt=31 left-shifts any value to bit 31 or below. No wrap: bits shifted out are lost.
- Latency from the Gnt cycle (cycle g) to first OutValid:
  - Amt=0: OutValid at cycle g+2.
  - Amt>0: OutValid at cycle g+2+ceil(Amt/STEP).
- Throughput: one transaction per latency + 1 IDLE cycle, minimum, with OutReady held high.

Test Plan:
- Reset then Req0, In0=0x5, Amt0=1, Dir0=0, OutReady=1 -> Gnt0 in cycle g; Out=0xA, OutId=0, OutValid at g+3; returns to IDLE.
- Req1, In1=0xC, Amt1=3, Dir1=1 -> Out=0x1, OutId=1. Then In1=0x3, Amt1=0 -> Out=0x3, OutValid at g+2.
- STEP=8, Req0, In0=0x1, Amt0=20, Dir0=0 -> Out=0x00100000, OutValid at g+5. Also Amt0=31, In0=0xFFFFFFFF -> Out=0x80000000.
- Req0 and Req1 held continuously after reset -> grants alternate 0,1,0,1. No Gnt is asserted while state≠IDLE; Gnt0 and Gnt1 are never both high.
- OutReady=0 for 5 cycles in DONE -> OutValid, Out and OutId stay stable; no Gnt; handshake on the 6th cycle -> IDLE next cycle.
- Rst=1 during SHIFT of In0=0x1, Amt0=31 -> next cycle OutValid=0, Out=0, state IDLE. A following Req0 and Req1 together grant requester 0 first.
